// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter: round-robin arbiter that sequences an N:1 data mux onto one
// output channel, holding each grant for a burst closed by last, a request drop or a beat limit.
`default_nettype none

module rr_mux_arbiter #(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int MAX_HOLD = 15,
  localparam int SW      = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic [N*DW-1:0] req_data,
  input  logic [N-1:0]    req_last,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [N-1:0]    gnt,
  output logic [SW-1:0]   sel,
  output logic            busy
);

  localparam logic [8:0] MAX_HOLD_C = 9'(MAX_HOLD);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sel_q, sel_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [SW-1:0] winner;
  logic [7:0]    hold_cnt, hold_nxt;
  logic [8:0]    cnt_plus;
  logic          found;
  logic          beat;
  logic          release_now;
  int            scan_idx;

  // First requester at or above ptr, wrapping N-1 -> 0.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = (int'(ptr) + k) % N;
      if (!found && req[scan_idx]) begin
        winner = SW'(scan_idx);
        found  = 1'b1;
      end
    end
  end

  assign busy      = (state == GRANT);
  assign out_valid = busy && req[sel_q];
  assign out_data  = out_valid ? req_data[int'(sel_q)*DW +: DW] : '0;
  assign gnt       = busy ? ({{(N-1){1'b0}}, 1'b1} << sel_q) : '0;
  assign sel       = sel_q;

  assign beat        = out_valid && out_ready;
  assign cnt_plus    = {1'b0, hold_cnt} + 9'd1;
  // A withdrawn request releases with no beat; last and the hold limit merge into one release.
  assign release_now = busy && (!req[sel_q] ||
                       (beat && (req_last[sel_q] || cnt_plus == MAX_HOLD_C)));

  always_comb begin
    state_nxt = state;
    sel_nxt   = sel_q;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          sel_nxt   = winner;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          state_nxt = IDLE;
          ptr_nxt   = (sel_q == SW'(N-1)) ? '0 : sel_q + SW'(1);
          sel_nxt   = '0;
          hold_nxt  = '0;
        end else if (beat) begin
          hold_nxt = (cnt_plus >= MAX_HOLD_C) ? MAX_HOLD_C[7:0] : cnt_plus[7:0];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel_q    <= '0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      sel_q    <= sel_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: directed scenarios plus a randomized
// run compared against a rule-level model of the arbitration.
`default_nettype none

module tb_rr_mux_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic        out_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: who owns the channel, where the next scan starts, beats so far.
  bit m_busy;
  int m_owner, m_ptr, m_beats;

  rr_mux_arbiter #(.N(4), .DW(8), .MAX_HOLD(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .gnt(gnt), .sel(sel), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_beats = 0;
  endtask

  task automatic model_edge();
    if (!m_busy) begin
      if (req != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (req[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            break;
          end
        end
        m_busy  = 1;
        m_beats = 0;
      end
    end else if (!req[m_owner]) begin
      m_ptr = (m_owner + 1) % 4; m_busy = 0;
    end else if (out_ready) begin
      m_beats++;
      if (req_last[m_owner] || m_beats == 15) begin
        m_ptr = (m_owner + 1) % 4; m_busy = 0;
      end
    end
  endtask

  // Advance one clock; inputs may be changed on return (1 time unit after the edge).
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; model_reset();
    req = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #2;
    n_checks++; if ({gnt, sel, busy, out_valid, out_data} !== 16'h0) $display("FAIL reset_state got gnt=%b sel=%0d busy=%b valid=%b data=%h want all zero", gnt, sel, busy, out_valid, out_data); else n_pass++;
    tick();
    req = 4'b0100; out_ready = 1'b0; req_data = 32'h00AB_0000;
    tick();
    #2;
    n_checks++; if (busy !== 1'b1) $display("FAIL reset_pre_busy got %b want 1", busy); else n_pass++;
    rst_n = 1'b0; model_reset();
    #1;
    n_checks++; if ({gnt, busy, out_valid} !== 6'b0) $display("FAIL reset_midburst got gnt=%b busy=%b valid=%b want 0", gnt, busy, out_valid); else n_pass++;
    tick();
    rst_n = 1'b1; req = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    tick();
    #2;
    n_checks++; if (gnt !== 4'b0001) $display("FAIL reset_ptr0 got %b want 0001", gnt); else n_pass++;
  endtask

  task automatic test_single();
    logic [7:0] d;
    do_reset();
    req = 4'b0100; req_last = 4'b0000; out_ready = 1'b1;
    #2;
    n_checks++; if (gnt !== 4'b0000) $display("FAIL single_latency got %b want 0000", gnt); else n_pass++;
    tick();
    #2;
    n_checks++; if (gnt !== 4'b0100 || sel !== 2'd2) $display("FAIL single_gnt got gnt=%b sel=%0d want 0100 sel=2", gnt, sel); else n_pass++;
    for (int b = 1; b <= 3; b++) begin
      d = 8'($urandom);
      req_data = {8'h00, d, 16'h0000};
      req_last = (b == 3) ? 4'b0100 : 4'b0000;
      #1;
      n_checks++; if (out_valid !== 1'b1 || out_data !== d) $display("FAIL single_beat%0d got valid=%b data=%h want 1 %h", b, out_valid, out_data, d); else n_pass++;
      tick();
    end
    req_last = 4'b0000;
    #2;
    n_checks++; if (gnt !== 4'b0000 || out_valid !== 1'b0) $display("FAIL single_gap got gnt=%b valid=%b want 0000 0", gnt, out_valid); else n_pass++;
    tick();
    #2;
    n_checks++; if (gnt !== 4'b0100) $display("FAIL single_regrant got %b want 0100", gnt); else n_pass++;
  endtask

  task automatic test_rotation();
    logic [3:0] exp;
    do_reset();
    req = 4'b1111; req_last = 4'b1111; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      exp = (c % 2 == 0) ? 4'b0000 : 4'(1 << (((c - 1) / 2) % 4));
      #2;
      n_checks++; if (gnt !== exp) $display("FAIL rotation_c%0d got %b want %b", c, gnt, exp); else n_pass++;
      tick();
    end
  endtask

  task automatic test_forced();
    int beats = 0;
    do_reset();
    req = 4'b1010; req_last = 4'b0000; out_ready = 1'b1;
    tick();
    for (int c = 0; c < 40; c++) begin
      #2;
      if (gnt !== 4'b0010) break;
      if (out_valid) beats++;
      tick();
    end
    n_checks++; if (beats !== 15) $display("FAIL forced_beats got %0d want 15", beats); else n_pass++;
    n_checks++; if (gnt !== 4'b0000) $display("FAIL forced_gap got %b want 0000", gnt); else n_pass++;
    tick();
    #2;
    n_checks++; if (gnt !== 4'b1000) $display("FAIL forced_next got %b want 1000", gnt); else n_pass++;
  endtask

  task automatic test_stall_withdraw();
    int held = 0;
    do_reset();
    req = 4'b0001; req_last = 4'b0001; out_ready = 1'b0; req_data = 32'h0000_005A;
    tick();
    for (int c = 0; c < 5; c++) begin
      req_data[7:0] = 8'($urandom);
      #2;
      if (gnt === 4'b0001 && out_valid === 1'b1 && out_data === req_data[7:0]) held++;
      tick();
    end
    n_checks++; if (held !== 5) $display("FAIL stall_hold got %0d want 5", held); else n_pass++;
    req = 4'b0000;
    #2;
    n_checks++; if (out_valid !== 1'b0 || gnt !== 4'b0001) $display("FAIL withdraw_pre got valid=%b gnt=%b want 0 0001", out_valid, gnt); else n_pass++;
    tick();
    #2;
    n_checks++; if (gnt !== 4'b0000 || busy !== 1'b0) $display("FAIL withdraw_rel got gnt=%b busy=%b want 0000 0", gnt, busy); else n_pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] d0, d1;
    do_reset();
    req = 4'b0100; req_last = 4'b0100; out_ready = 1'b1;
    tick(); tick();
    d0 = 8'($urandom); d1 = 8'($urandom);
    req = 4'b0011; req_last = 4'b0011; req_data = {16'h0000, d1, d0};
    tick();
    #2;
    n_checks++; if (sel !== 2'd0 || out_data !== d0) $display("FAIL wrap_first got sel=%0d data=%h want 0 %h", sel, out_data, d0); else n_pass++;
    tick(); tick();
    #2;
    n_checks++; if (sel !== 2'd1 || out_data !== d1) $display("FAIL wrap_second got sel=%0d data=%h want 1 %h", sel, out_data, d1); else n_pass++;
  endtask

  task automatic test_random();
    logic       e_valid;
    logic [7:0] e_data;
    logic [3:0] e_gnt;
    logic [1:0] e_sel;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(7) == 0) req[i] = ~req[i];
      for (int i = 0; i < 4; i++) req_last[i] = ($urandom_range(3) == 0);
      out_ready = ($urandom_range(3) != 0);
      req_data  = $urandom;
      #2;
      e_valid = m_busy && req[m_owner];
      e_data  = e_valid ? req_data[m_owner*8 +: 8] : 8'h00;
      e_gnt   = m_busy ? 4'(1 << m_owner) : 4'b0000;
      e_sel   = m_busy ? 2'(m_owner) : 2'd0;
      n_checks++; if (gnt !== e_gnt) $display("FAIL rand_gnt c%0d got %b want %b", c, gnt, e_gnt); else n_pass++;
      n_checks++; if (sel !== e_sel) $display("FAIL rand_sel c%0d got %0d want %0d", c, sel, e_sel); else n_pass++;
      n_checks++; if (busy !== m_busy) $display("FAIL rand_busy c%0d got %b want %b", c, busy, m_busy); else n_pass++;
      n_checks++; if (out_valid !== e_valid || out_data !== e_data) $display("FAIL rand_out c%0d got %b/%h want %b/%h", c, out_valid, out_data, e_valid, e_data); else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_forced();
    test_stall_withdraw();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
